// File: rtl/aes_enc_iter.sv
// Iterative AES-128/256 encryptor: one round per clock, in-core key expansion, valid/ready in and out.
// Optional CBC chaining is built only when AES_CBC_EN is defined; otherwise every block is ECB.
module aes_enc_iter #(
   parameter int KEY_BITS = 128
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                key_load,
   input  logic [KEY_BITS-1:0] key,
   output logic                key_ready,
   output logic                key_err,
   input  logic                iv_load,
   input  logic [127:0]        iv,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [127:0]        in_data,
   input  logic                cbc_en,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [127:0]        out_data,
   output logic                busy
);

   localparam int NK = KEY_BITS / 32;
   localparam int NR = NK + 6;
   localparam int NW = 4 * (NR + 1);
   localparam logic [3:0] LAST_ROUND = 4'(NR);
   localparam logic [5:0] LAST_WORD  = 6'(NW - 1);
   localparam logic [5:0] NK_MASK    = 6'(NK - 1);

   if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
      $error("aes_enc_iter: KEY_BITS must be 128 or 256");
   end

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[8*(255 - int'(b)) +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // Byte 4*c+r of the block sits at row r, column c; MSB byte is byte 0.
   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
         end
      end
      return o;
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      return {mix_column(s[127:96]), mix_column(s[95:64]),
              mix_column(s[63:32]), mix_column(s[31:0])};
   endfunction

   typedef enum logic [1:0] {IDLE, KEXP, ROUND} state_t;

   state_t        state, next_state;
   logic [3:0]    round_ctr;
   logic [5:0]    kidx;
   logic [7:0]    rcon;
   logic [127:0]  state_block;
   logic [31:0]   rk_mem [NW];
   logic [31:0]   win [NK];
   logic [31:0]   temp_word, new_word;
   logic [5:0]    rk_base;
   logic [127:0]  rk0, rk_cur, shifted, round_out, chain_mix;
   logic          kexp_start, kexp_step, kexp_done, key_reject;
   logic          accept, deliver;

   assign in_ready   = (state == IDLE) && key_ready && !key_load;
   assign busy       = (state != IDLE);
   assign accept     = in_valid && in_ready;
   assign kexp_start = key_load && (state != ROUND);
   assign key_reject = key_load && (state == ROUND);
   assign kexp_step  = (state == KEXP) && !key_load;
   assign kexp_done  = kexp_step && (kidx == LAST_WORD);
   assign deliver    = (state == ROUND) && (round_ctr == LAST_ROUND) && (!out_valid || out_ready);

   // win[] holds the previous NK schedule words: win[0] = w[i-NK], win[NK-1] = w[i-1].
   always_comb begin
      temp_word = win[NK-1];
      if ((kidx & NK_MASK) == 6'd0) begin
         temp_word = sub_word({temp_word[23:0], temp_word[31:24]}) ^ {rcon, 24'h0};
      end else if (NK == 8 && kidx[2:0] == 3'd4) begin
         temp_word = sub_word(temp_word);
      end
      new_word = win[0] ^ temp_word;
   end

   always_comb begin
      rk_base   = {round_ctr, 2'b00};
      rk0       = {rk_mem[0], rk_mem[1], rk_mem[2], rk_mem[3]};
      rk_cur    = {rk_mem[rk_base], rk_mem[rk_base + 6'd1],
                   rk_mem[rk_base + 6'd2], rk_mem[rk_base + 6'd3]};
      shifted   = sub_shift(state_block);
      round_out = (round_ctr == LAST_ROUND) ? (shifted ^ rk_cur)
                                            : (mix_columns(shifted) ^ rk_cur);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // NOTE: combinational blocks assign a default first so no path can infer a latch.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (key_load)    next_state = KEXP;
            else if (accept) next_state = ROUND;
         end
         KEXP:    if (kexp_done) next_state = IDLE;
         ROUND:   if (deliver)   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // NOTE: round-key storage has no reset; key_ready gates every read of it.
   always_ff @(posedge clk) begin
      if (kexp_start) begin
         for (int j = 0; j < NK; j++) begin
            win[j]    <= key[KEY_BITS-1-32*j -: 32];
            rk_mem[j] <= key[KEY_BITS-1-32*j -: 32];
         end
      end else if (kexp_step) begin
         for (int j = 0; j < NK - 1; j++) win[j] <= win[j+1];
         win[NK-1]    <= new_word;
         rk_mem[kidx] <= new_word;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_ready   <= 1'b0;
         key_err     <= 1'b0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         round_ctr   <= '0;
         kidx        <= '0;
         rcon        <= '0;
         state_block <= '0;
      end else begin
         key_err <= key_reject;

         if (kexp_start) begin
            key_ready <= 1'b0;
            kidx      <= 6'(NK);
            rcon      <= 8'h01;
         end else if (kexp_step) begin
            kidx <= kidx + 6'd1;
            if ((kidx & NK_MASK) == 6'd0) rcon <= xtime(rcon);
            if (kexp_done) key_ready <= 1'b1;
         end

         if (accept) begin
            state_block <= in_data ^ chain_mix ^ rk0;
            round_ctr   <= 4'd1;
         end else if (state == ROUND && round_ctr != LAST_ROUND) begin
            state_block <= round_out;
            round_ctr   <= round_ctr + 4'd1;
         end

         // A fresh result may replace the one being handed off in the same cycle.
         if (deliver) begin
            out_data  <= round_out;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef AES_CBC_EN
   logic [127:0] chain;

   // iv_load alongside an accept: the block already sampled the old chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                            chain <= '0;
      else if (deliver)                   chain <= round_out;
      else if (state == IDLE && iv_load)  chain <= iv;
   end

   assign chain_mix = cbc_en ? chain : '0;
`else
   logic unused_cbc;
   assign unused_cbc = ^{iv_load, iv, cbc_en};
   assign chain_mix  = '0;
`endif

endmodule
